icache_dm: RTL

Direct-mapped, parametrised instruction cache for the fetch stage. It returns a 32-bit big-endian instruction word combinationally on a hit. On a miss it raises `stall` and refills a whole line from a word-wide backing-memory port through a request/acknowledge handshake. The `Metal` parameter selects the 64 KiB Metal-mode address window, so one block serves both the normal and the Metal fetch paths.

---
 rtl/icache_dm.sv | 108 ++++++++++
 1 files changed

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: zero-latency hits and whole-line refill over a
// word-wide request/acknowledge backing-memory port. Metal=1 restricts fetches to a 64 KiB window.
module icache_dm #(
    parameter int Metal      = 0,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] addr,
    input  logic        read_en,
    input  logic        flush,
    output logic [31:0] data,
    output logic        stall,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
);
    localparam int OFF_BITS = $clog2(LINE_WORDS);
    localparam int IDX_BITS = $clog2(SETS);
    localparam int FLAT_W   = OFF_BITS + IDX_BITS;
    localparam int TAG_BITS = 62 - FLAT_W;
    localparam int BEAT_W   = (OFF_BITS == 0) ? 1 : OFF_BITS;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [63:0]       LINE_MASK = ~64'(LINE_WORDS * 4 - 1);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t              state;
    logic [SETS-1:0]     valid;
    logic [TAG_BITS-1:0] tag_arr [SETS];
    logic [31:0]         data_arr [SETS*LINE_WORDS];
    logic [IDX_BITS-1:0] miss_idx;
    logic [TAG_BITS-1:0] miss_tag;
    logic [BEAT_W-1:0]   beat;
    logic                kill;

    logic [63:0]         ea;
    logic [IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic [FLAT_W-1:0]   flat;
    logic [FLAT_W-1:0]   refill_flat;
    logic                hit;
    logic                miss;
    logic                last_ack;

    assign ea       = (Metal != 0) ? (addr & 64'h0ffff) : addr;
    assign idx      = ea[2+OFF_BITS +: IDX_BITS];
    assign tag      = ea[63 -: TAG_BITS];
    assign flat     = ea[2 +: FLAT_W];
    assign hit      = read_en && valid[idx] && (tag_arr[idx] == tag);
    assign miss     = (state == IDLE) && read_en && !hit;
    assign stall    = (state == REFILL) || miss;
    assign data     = data_arr[flat];
    assign last_ack = (state == REFILL) && mem_ack && (beat == LAST_BEAT);

    // With one word per line the beat counter carries a spare bit that must not reach the array index.
    assign refill_flat = FLAT_W'({miss_idx, beat} >> (BEAT_W - OFF_BITS));

    always_ff @(posedge clk) begin
        if (!reset && state == REFILL && mem_ack)
            data_arr[refill_flat] <= mem_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            valid    <= '0;
            kill     <= 1'b0;
            beat     <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            if (flush)
                valid <= '0;
            case (state)
                IDLE: begin
                    if (miss) begin
                        miss_idx <= idx;
                        miss_tag <= tag;
                        beat     <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= ea & LINE_MASK;
                        state    <= REFILL;
                    end
                end
                REFILL: begin
                    if (flush)
                        kill <= 1'b1;
                    if (mem_ack) begin
                        beat     <= beat + BEAT_W'(1);
                        mem_addr <= mem_addr + 64'd4;
                    end
                    // A flush seen at any point of the refill leaves the new line invalid.
                    if (last_ack) begin
                        tag_arr[miss_idx] <= miss_tag;
                        if (!flush && !kill)
                            valid[miss_idx] <= 1'b1;
                        kill    <= 1'b0;
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
